shot_pool_controller: RTL
=========================

# shot_pool_controller

Owns a fixed pool of player shot slots and sequences them once per video frame: it accepts fire requests, enforces a per-frame cooldown, allocates free slots, advances every live shot upward, and retires shots that leave the screen top or are reported hit. Its per-slot position and active outputs drive the top-left offsets and enables of the shot bitmap/rectangle instances. It sits between the player/keyboard logic and the shot drawing objects, alongside the collision detector that reports hits.

## Interface
- NUM_SHOTS, 4, number of shot slots (2..8)
- COOLDOWN_FRAMES, 8, frames between accepted shots (1..63)
- SHOT_SPEED, 4, pixels moved up per frame (1..15)
- SCREEN_TOP, 0, y at/above which a shot retires
- SPAWN_DX, 0, x offset added to playerX at spawn

- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- fireReq  in  1  level, fire button
- playerX  in  11  player top-left x
- playerY  in  11  player top-left y
- hitShot  in  NUM_SHOTS  one-cycle hit pulse per slot from collision logic
- shotActive  out  NUM_SHOTS  slot i live
- shotX  out  NUM_SHOTS*11  slot i x in bits [11i+10:11i]
- shotY  out  NUM_SHOTS*11  slot i y, same packing
- fireAccepted  out  1  one-cycle pulse when a shot spawns
- poolFull  out  1  combinational AND of shotActive

## Operation
- FSM states: IDLE, MOVE, SPAWN. Registered slot index idx (3 bits).
- IDLE: on startOfFrame -> MOVE, idx=0. Otherwise hold.
- MOVE: one slot per cycle. If active: if shotY < SCREEN_TOP+SHOT_SPEED clear active, else shotY -= SHOT_SPEED (11-bit unsigned, compare done before subtract so no wrap). Inactive slot untouched. idx==NUM_SHOTS-1 -> SPAWN.
- SPAWN: if cooldown!=0 decrement it. Else if firePending and a free slot exists: lowest free index i gets active=1, shotX=playerX+SPAWN_DX (mod 2^11), shotY=playerY; cooldown=COOLDOWN_FRAMES; firePending cleared; fireAccepted pulses next cycle. Pool full -> firePending kept. Always -> IDLE.
- firePending: set in any state on fire event (see Configuration); cleared only by spawn.
- hitShot[i] in any cycle clears active[i]; hit beats move of the same slot in the same cycle; hit on an inactive slot ignored (including the slot being spawned that cycle: spawn proceeds).
- startOfFrame while not IDLE: ignored.
- Reset (any time, including mid-MOVE): state IDLE, idx 0, all shotActive/shotX/shotY 0, cooldown 0, firePending 0, fireAccepted 0.

## Timing
- Frame sequence: startOfFrame at cycle T -> MOVE cycles T+1..T+NUM_SHOTS -> SPAWN at T+NUM_SHOTS+1 -> IDLE.
- Position updates visible on outputs the cycle after the MOVE cycle for that slot; all updates complete NUM_SHOTS+2 cycles after startOfFrame, far inside vertical blanking.
- fireAccepted high exactly one cycle, at T+NUM_SHOTS+2; new slot's outputs valid the same cycle.
- Hit clear visible the cycle after the hitShot pulse.
- Minimum spawn spacing: COOLDOWN_FRAMES+1 frames.

## Configuration
- SHOT_AUTOFIRE_EN defined: fire event = fireReq high in any cycle; holding fire spawns every COOLDOWN_FRAMES+1 frames while slots are free.
- Undefined: fire event = rising edge of fireReq (registered previous value, reset 0); holding fire yields one shot, re-press required.

## Test plan
- Reset then fireReq pulse, one startOfFrame, playerX=100, playerY=400 -> fireAccepted at T+6, shotActive=0001, slot0 x=100 y=400; next frame y=396.
- Shot at y=5, SHOT_SPEED=4: frame -> y=1; next frame -> retired, shotActive bit 0 clears, no wrap to 2045.
- Autofire held (macro defined), 40 frames -> spawns at frames 0,9,18,27 into slots 0..3; poolFull=1; fire pending, no spawn until a slot frees, then lowest free slot used.
- Macro undefined, fireReq held 40 frames -> exactly one fireAccepted.
- hitShot[1] in the same cycle slot 1 is in MOVE -> slot 1 cleared, y unchanged; hitShot[2] with slot 2 inactive -> no effect.
- resetN low during MOVE with 3 live shots -> all outputs 0 immediately; after release first startOfFrame runs full sequence from IDLE.

Source files
------------

// File: rtl/shot_pool_controller_if.sv
// rtl/shot_pool_controller_if.sv - frame/fire/hit inputs and per-slot shot outputs of the shot pool
interface shot_pool_controller_if #(
    parameter int NUM_SHOTS = 4
);
    logic                     startOfFrame;
    logic                     fireReq;
    logic [10:0]              playerX;
    logic [10:0]              playerY;
    logic [NUM_SHOTS-1:0]     hitShot;
    logic [NUM_SHOTS-1:0]     shotActive;
    logic [NUM_SHOTS*11-1:0]  shotX;
    logic [NUM_SHOTS*11-1:0]  shotY;
    logic                     fireAccepted;
    logic                     poolFull;

    modport master (
        output startOfFrame, fireReq, playerX, playerY, hitShot,
        input  shotActive, shotX, shotY, fireAccepted, poolFull
    );

    modport slave (
        input  startOfFrame, fireReq, playerX, playerY, hitShot,
        output shotActive, shotX, shotY, fireAccepted, poolFull
    );
endinterface

// File: rtl/shot_pool_controller.sv
// rtl/shot_pool_controller.sv - per-frame shot slot sequencer: move, retire, cooldown, spawn
// Optional SHOT_AUTOFIRE_EN: fire level (not edge) requests a shot.
module shot_pool_controller #(
    parameter int NUM_SHOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SHOT_SPEED      = 4,
    parameter int SCREEN_TOP      = 0,
    parameter int SPAWN_DX        = 0
) (
    input  logic                     clk,
    input  logic                     resetN,
    shot_pool_controller_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_e;

    localparam logic [11:0] RETIRE_LIM = 12'(SCREEN_TOP + SHOT_SPEED);
    localparam logic [10:0] STEP       = 11'(SHOT_SPEED);
    localparam logic [10:0] DX         = 11'(SPAWN_DX);
    localparam logic [2:0]  LAST_IDX   = 3'(NUM_SHOTS - 1);

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_SHOTS-1:0]  active_q, active_d;
    logic [10:0]           x_q [NUM_SHOTS];
    logic [10:0]           x_d [NUM_SHOTS];
    logic [10:0]           y_q [NUM_SHOTS];
    logic [10:0]           y_d [NUM_SHOTS];
    logic [5:0]            cooldown_q, cooldown_d;
    logic                  pend_q, pend_d;
    logic                  acc_q, acc_d;
    logic                  fire_evt;
    logic                  free_found;
    logic [2:0]            free_idx;

`ifdef SHOT_AUTOFIRE_EN
    assign fire_evt = bus.fireReq;
`else
    logic fire_prev_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) fire_prev_q <= 1'b0;
        else         fire_prev_q <= bus.fireReq;
    end

    assign fire_evt = bus.fireReq & ~fire_prev_q;
`endif

    // Lowest free slot wins: scan downward so the smallest index is written last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        active_d   = active_q;
        x_d        = x_q;
        y_d        = y_q;
        cooldown_d = cooldown_q;
        pend_d     = pend_q;
        acc_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.startOfFrame) begin
                    state_d = MOVE;
                    idx_d   = '0;
                end
            end
            MOVE: begin
                for (int i = 0; i < NUM_SHOTS; i++) begin
                    // A same-cycle hit takes precedence, so the position is left frozen.
                    if (idx_q == 3'(i) && active_q[i] && !bus.hitShot[i]) begin
                        if ({1'b0, y_q[i]} < RETIRE_LIM) active_d[i] = 1'b0;
                        else                             y_d[i]      = y_q[i] - STEP;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = SPAWN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SPAWN: begin
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - 6'd1;
                end else if (pend_q && free_found) begin
                    for (int i = 0; i < NUM_SHOTS; i++) begin
                        if (free_idx == 3'(i)) begin
                            active_d[i] = 1'b1;
                            x_d[i]      = bus.playerX + DX;
                            y_d[i]      = bus.playerY;
                        end
                    end
                    cooldown_d = 6'(COOLDOWN_FRAMES);
                    pend_d     = 1'b0;
                    acc_d      = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fire_evt) pend_d = 1'b1;

        // Hits only retire slots that were already live; a slot spawning now is unaffected.
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (bus.hitShot[i] && active_q[i]) active_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            active_q   <= '0;
            cooldown_q <= '0;
            pend_q     <= 1'b0;
            acc_q      <= 1'b0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            cooldown_q <= cooldown_d;
            pend_q     <= pend_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        bus.shotX = '0;
        bus.shotY = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            bus.shotX[11*i +: 11] = x_q[i];
            bus.shotY[11*i +: 11] = y_q[i];
        end
    end

    assign bus.shotActive   = active_q;
    assign bus.fireAccepted = acc_q;
    assign bus.poolFull     = &active_q;

endmodule
